// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle between the sequencer, alu_seq and the writeback stage.
interface alu_seq_if #(parameter int WIDTH = 8);
    logic             in_valid, in_ready, out_valid, out_ready, carry, zero, dz;
    logic [WIDTH-1:0] a, b, r, r_hi;
    logic [3:0]       op;
    modport master (output in_valid, a, b, op, out_ready, input in_ready, out_valid, r, r_hi, carry, zero, dz);
    modport slave  (input in_valid, a, b, op, out_ready, output in_ready, out_valid, r, r_hi, carry, zero, dz);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes and iterative shift-add MUL / restoring DIV.
module alu_seq #(parameter int WIDTH = 8) (
    input logic     clk,
    input logic     rst,
    alu_seq_if.slave bus
);
    localparam int W  = WIDTH;
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t         state_q, state_d;
    logic [W-1:0]   hi_q, hi_d, lo_q, lo_d, m_q, m_d, r_q, r_d, r_hi_q, r_hi_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           carry_q, carry_d, zero_q, zero_d, dz_q, dz_d, out_valid_q, out_valid_d;
    logic [W-1:0]   a, b, s_r, s_hi;
    logic           s_c, s_dz, ge, last;
    logic [W:0]     sum, shl;
    assign a = bus.a;
    assign b = bus.b;
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.r         = r_q;
    assign bus.r_hi      = r_hi_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.dz        = dz_q;
    always_comb begin
        s_r  = '0;
        s_hi = '0;
        s_c  = 1'b0;
        s_dz = 1'b0;
        case (bus.op)
            4'd0: {s_c, s_r} = {1'b0, a} + {1'b0, b};
            4'd1: begin s_r = a - b; s_c = a < b; end
            // Only the b==0 case of DIV completes in a single cycle
            4'd3: begin s_r = '1; s_hi = a; s_dz = 1'b1; end
            4'd4: {s_c, s_r} = {a, 1'b0};
            4'd5: {s_r, s_c} = {1'b0, a};
            4'd6: begin s_r = {a[W-2:0], a[W-1]}; s_c = a[W-1]; end
            4'd7: begin s_r = {a[0], a[W-1:1]}; s_c = a[0]; end
            4'd8: s_r = a & b;
            4'd9: s_r = a | b;
            4'd10: s_r = a ^ b;
            4'd11: s_r = ~(a & b);
            4'd12: s_r = ~(a | b);
            4'd13: s_r = ~a;
            4'd14: s_r = -a;
            4'd15: s_r = {{(W-1){1'b0}}, a == b};
            default: ;
        endcase
    end
    // MUL keeps {hi,lo} as partial product / remaining multiplier; DIV keeps remainder / quotient
    assign sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    assign shl  = {hi_q, lo_q[W-1]};
    assign ge   = shl >= {1'b0, m_q};
    assign last = cnt_q == CW'(W - 1);
    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        m_d         = m_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        r_hi_d      = r_hi_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        dz_d        = dz_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                cnt_d = '0;
                hi_d  = '0;
                if (bus.op == 4'd2) begin
                    state_d = MUL;
                    lo_d    = b;
                    m_d     = a;
                end else if (bus.op == 4'd3 && b != '0) begin
                    state_d = DIV;
                    lo_d    = a;
                    m_d     = b;
                end else begin
                    state_d     = DONE;
                    r_d         = s_r;
                    r_hi_d      = s_hi;
                    carry_d     = s_c;
                    zero_d      = s_r == '0;
                    dz_d        = s_dz;
                    out_valid_d = 1'b1;
                end
            end
            MUL: {hi_d, lo_d} = {sum, lo_q[W-1:1]};
            DIV: begin
                hi_d = ge ? W'(shl - {1'b0, m_q}) : shl[W-1:0];
                lo_d = {lo_q[W-2:0], ge};
            end
            DONE: if (bus.out_ready) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (state_q == MUL || state_q == DIV) begin
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                state_d     = DONE;
                r_d         = lo_d;
                r_hi_d      = hi_d;
                carry_d     = 1'b0;
                zero_d      = lo_d == '0;
                dz_d        = 1'b0;
                out_valid_d = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hi_q        <= '0;
            lo_q        <= '0;
            m_q         <= '0;
            cnt_q       <= '0;
            r_q         <= '0;
            r_hi_q      <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            m_q         <= m_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            r_hi_q      <= r_hi_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            dz_q        <= dz_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table, randomized ops against an arithmetic model, backpressure and reset sequences.
module tb_alu_seq;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    alu_seq_if #(.WIDTH(W)) bus();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        logic [7:0] r, hi;
        logic       c, z, dz;
        int         lat;
    } res_t;
    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b, r, hi;
        logic       c, z, dz;
        int         lat;
    } vec_t;
    function automatic res_t model(input int op, input int a, input int b);
        res_t m;
        int v, h, c, dz;
        v = 0; h = 0; c = 0; dz = 0;
        case (op)
            0: begin v = a + b; c = v / 256; end
            1: begin v = a - b + 256; c = (a < b) ? 1 : 0; end
            2: begin v = a * b; h = v / 256; end
            3: if (b == 0) begin v = 255; h = a; dz = 1; end else begin v = a / b; h = a % b; end
            4: begin v = a * 2; c = a / 128; end
            5: begin v = a / 2; c = a % 2; end
            6: begin v = a * 2 + a / 128; c = a / 128; end
            7: begin v = a / 2 + (a % 2) * 128; c = a % 2; end
            8: v = a & b;
            9: v = a | b;
            10: v = a ^ b;
            11: v = 255 - (a & b);
            12: v = 255 - (a | b);
            13: v = 255 - a;
            14: v = 256 - a;
            default: v = (a == b) ? 1 : 0;
        endcase
        m.r   = 8'(v % 256);
        m.hi  = 8'(h % 256);
        m.c   = c[0];
        m.dz  = dz[0];
        m.z   = (v % 256) == 0;
        m.lat = (op == 2 || (op == 3 && b != 0)) ? W + 1 : 1;
        return m;
    endfunction
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask
    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input res_t e, input string tag);
        int lat;
        int busy_bad;
        @(negedge clk);
        chk({tag, " in_ready idle"}, 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.op = 4'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
        lat = 1;
        busy_bad = 0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) busy_bad++;
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(e.lat));
        chk({tag, " in_ready busy"}, 32'(busy_bad + int'(bus.in_ready)), 0);
        chk({tag, " r"}, 32'(bus.r), 32'(e.r));
        chk({tag, " r_hi"}, 32'(bus.r_hi), 32'(e.hi));
        chk({tag, " carry"}, 32'(bus.carry), 32'(e.c));
        chk({tag, " zero"}, 32'(bus.zero), 32'(e.z));
        chk({tag, " dz"}, 32'(bus.dz), 32'(e.dz));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, " out_valid drop"}, 32'(bus.out_valid), 0);
    endtask
    vec_t vt[13];
    initial begin
        res_t e;
        logic [3:0] op;
        logic [7:0] a, b;
        int seen;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        vt[0]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1};
        vt[1]  = '{4'd2,  8'h0F, 8'h11, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 9};
        vt[2]  = '{4'd2,  8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 9};
        vt[3]  = '{4'd3,  8'hC8, 8'h07, 8'h1C, 8'h04, 1'b0, 1'b0, 1'b0, 9};
        vt[4]  = '{4'd3,  8'hC8, 8'h00, 8'hFF, 8'hC8, 1'b0, 1'b0, 1'b1, 1};
        vt[5]  = '{4'd6,  8'h81, 8'h00, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0, 1};
        vt[6]  = '{4'd7,  8'h81, 8'h00, 8'hC0, 8'h00, 1'b1, 1'b0, 1'b0, 1};
        vt[7]  = '{4'd1,  8'h03, 8'h05, 8'hFE, 8'h00, 1'b1, 1'b0, 1'b0, 1};
        vt[8]  = '{4'd15, 8'h5A, 8'h5A, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1};
        vt[9]  = '{4'd14, 8'h00, 8'h33, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1};
        vt[10] = '{4'd4,  8'h80, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1};
        vt[11] = '{4'd12, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1};
        vt[12] = '{4'd3,  8'h05, 8'h09, 8'h00, 8'h05, 1'b0, 1'b1, 1'b0, 9};
        repeat (2) @(negedge clk);
        chk("reset in_ready", 32'(bus.in_ready), 0);
        chk("reset out_valid", 32'(bus.out_valid), 0);
        chk("reset r", 32'(bus.r), 0);
        chk("reset r_hi", 32'(bus.r_hi), 0);
        chk("reset flags", 32'({bus.carry, bus.zero, bus.dz}), 0);
        rst = 1'b0;
        for (int i = 0; i < 13; i++) begin
            e = '{vt[i].r, vt[i].hi, vt[i].c, vt[i].z, vt[i].dz, vt[i].lat};
            run_op(vt[i].op, vt[i].a, vt[i].b, e, $sformatf("vec%0d", i));
        end
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            run_op(op, a, b, model(int'(op), int'(a), int'(b)), $sformatf("rnd%0d op%0d", i, op));
        end
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 4'd0; bus.a = 8'h12; bus.b = 8'h34;
        @(negedge clk);
        chk("bp out_valid", 32'(bus.out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.op = 4'd2; bus.a = 8'($urandom); bus.b = 8'($urandom);
            @(negedge clk);
            chk($sformatf("bp hold%0d", i), 32'({bus.out_valid, bus.in_ready, bus.r, bus.r_hi, bus.carry, bus.zero, bus.dz}), 32'({1'b1, 1'b0, 8'h46, 8'h00, 3'b000}));
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("bp no late accept", 32'({bus.out_valid, bus.in_ready}), 32'(2'b01));
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 4'd2; bus.a = 8'h0F; bus.b = 8'h11;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mul abort out_valid", 32'(bus.out_valid), 0);
        chk("mul abort in_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("mul abort no result", 32'(seen), 0);
        run_op(4'd0, 8'hFF, 8'h01, model(0, 255, 1), "post-rst add");
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 4'd0; bus.a = 8'h01; bus.b = 8'h02;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("done pre-rst r", 32'(bus.r), 32'(8'h03));
        #2 rst = 1'b1;
        #1;
        chk("async rst out_valid", 32'(bus.out_valid), 0);
        chk("async rst r", 32'(bus.r), 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(4'd3, 8'hC8, 8'h07, model(3, 200, 7), "post-rst div");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
